// File: rtl/buffer_and_demux.sv
// 1-to-NUM_LANES registered distributor: a one-hot select steers each upstream word
// into that lane's holding register, and words with an illegal select are dropped and counted.
module buffer_and_demux #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_LANES  = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_LANES-1:0]             in_sel,
  input  logic [DATA_WIDTH-1:0]            in_data,
  output logic [NUM_LANES-1:0]             lane_valid,
  input  logic [NUM_LANES-1:0]             lane_ready,
  output logic [NUM_LANES*DATA_WIDTH-1:0]  lane_data,
  output logic [CNT_WIDTH-1:0]             drop_count,
  output logic                             sel_err,
  input  logic                             err_clr
);

  localparam logic [NUM_LANES-1:0] SEL_ONE = NUM_LANES'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic                 sel_legal;
  logic                 accept;
  logic [NUM_LANES-1:0] lane_free;
  logic [NUM_LANES-1:0] load;

  // A lane can take a word when it is empty or being drained in the same cycle.
  // Illegal selects always report ready so the drop path never stalls upstream.
  always_comb begin
    sel_legal = (in_sel != '0) && ((in_sel & (in_sel - SEL_ONE)) == '0);
    lane_free = ~lane_valid | lane_ready;
    in_ready  = reset_n & (~sel_legal | (|(in_sel & lane_free)));
    accept    = in_valid & in_ready;
    load      = (accept & sel_legal) ? in_sel : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lane_valid <= '0;
      lane_data  <= '0;
      drop_count <= '0;
      sel_err    <= 1'b0;
    end else begin
      lane_valid <= (lane_valid & ~lane_ready) | load;
      for (int i = 0; i < NUM_LANES; i++) begin
        if (load[i]) lane_data[i*DATA_WIDTH +: DATA_WIDTH] <= in_data;
      end
      // Clearing wins over a drop arriving in the same cycle.
      if (err_clr) begin
        drop_count <= '0;
        sel_err    <= 1'b0;
      end else if (accept && !sel_legal) begin
        if (drop_count != CNT_MAX) drop_count <= drop_count + CNT_WIDTH'(1);
        sel_err <= 1'b1;
      end
    end
  end

endmodule
